// File: rtl/sp_hit_filter.sv
// rtl/sp_hit_filter.sv - direct-mapped read-hit filter between kernel BRAM ports and the host bridge
// Optional feature: define SP_STATS_EN to build the hit_cnt/miss_cnt counters (otherwise they read 0).
module sp_hit_filter #(
  parameter int ADDR_WID = 14,
  parameter int DATA_WID = 32,
  parameter int SP_AW    = 8
) (
  input  logic                mod_clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [ADDR_WID-1:0] k_addr0,
  input  logic [ADDR_WID-1:0] k_addr1,
  input  logic                k_ce0,
  input  logic                k_ce1,
  input  logic                k_we0,
  input  logic                k_we1,
  input  logic [DATA_WID-1:0] k_d0,
  input  logic [DATA_WID-1:0] k_d1,
  output logic [DATA_WID-1:0] k_q0,
  output logic [DATA_WID-1:0] k_q1,
  output logic [ADDR_WID-1:0] m_addr0,
  output logic [ADDR_WID-1:0] m_addr1,
  output logic                m_ce0,
  output logic                m_ce1,
  output logic                m_we0,
  output logic                m_we1,
  output logic [DATA_WID-1:0] m_d0,
  output logic [DATA_WID-1:0] m_d1,
  input  logic [DATA_WID-1:0] m_q0,
  input  logic [DATA_WID-1:0] m_q1,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
);

  localparam int TAG_W = ADDR_WID - SP_AW;
  localparam int LINES = 1 << SP_AW;

  typedef enum logic [1:0] {SRC_LOCAL, SRC_BRIDGE0, SRC_BRIDGE1} src_t;

  logic [DATA_WID-1:0] data_mem [LINES];
  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [LINES-1:0]    valid;

  logic [SP_AW-1:0] idx0, idx1;
  logic [TAG_W-1:0] tag0, tag1;
  logic             rd0, rd1, wr0, wr1, same_addr;
  logic             hit0, hit1, miss0, miss1, dedup;

  assign idx0      = k_addr0[SP_AW-1:0];
  assign idx1      = k_addr1[SP_AW-1:0];
  assign tag0      = k_addr0[ADDR_WID-1:SP_AW];
  assign tag1      = k_addr1[ADDR_WID-1:SP_AW];
  assign rd0       = k_ce0 & ~k_we0;
  assign rd1       = k_ce1 & ~k_we1;
  assign wr0       = k_ce0 & k_we0;
  assign wr1       = k_ce1 & k_we1;
  assign same_addr = (k_addr0 == k_addr1);

  assign hit0  = rd0 & valid[idx0] & (tag_mem[idx0] == tag0);
  // The bridge applies a port0 write before a port1 read, so such a read must go out to see it
  assign hit1  = rd1 & valid[idx1] & (tag_mem[idx1] == tag1) & ~(wr0 & same_addr);
  assign miss0 = rd0 & ~hit0;
  assign dedup = miss0 & rd1 & ~hit1 & same_addr;
  assign miss1 = rd1 & ~hit1 & ~dedup;

  assign m_addr0 = k_addr0;
  assign m_addr1 = k_addr1;
  assign m_d0    = k_d0;
  assign m_d1    = k_d1;
  assign m_we0   = k_we0;
  assign m_we1   = k_we1;
  assign m_ce0   = k_ce0 & ~hit0;
  assign m_ce1   = k_ce1 & ~hit1 & ~dedup;

  src_t                src0, src1;
  logic [DATA_WID-1:0] loc0, loc1;

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      src0 <= SRC_LOCAL;
      src1 <= SRC_LOCAL;
      loc0 <= '0;
      loc1 <= '0;
    end else begin
      if (rd0) begin
        src0 <= hit0 ? SRC_LOCAL : SRC_BRIDGE0;
        loc0 <= data_mem[idx0];
      end
      if (rd1) begin
        src1 <= hit1 ? SRC_LOCAL : (dedup ? SRC_BRIDGE0 : SRC_BRIDGE1);
        loc1 <= data_mem[idx1];
      end
    end
  end

  always_comb begin
    case (src0)
      SRC_BRIDGE0: k_q0 = m_q0;
      SRC_BRIDGE1: k_q0 = m_q1;
      default:     k_q0 = loc0;
    endcase
    case (src1)
      SRC_BRIDGE0: k_q1 = m_q0;
      SRC_BRIDGE1: k_q1 = m_q1;
      default:     k_q1 = loc1;
    endcase
  end

  logic             pf_vld0, pf_vld1;
  logic [SP_AW-1:0] pf_idx0, pf_idx1;
  logic [TAG_W-1:0] pf_tag0, pf_tag1;

  // A port0 miss paired with a port1 write to the same word returns pre-write data; never cache it
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      pf_vld0 <= 1'b0;
      pf_vld1 <= 1'b0;
      pf_idx0 <= '0;
      pf_idx1 <= '0;
      pf_tag0 <= '0;
      pf_tag1 <= '0;
    end else begin
      pf_vld0 <= miss0 & ~(wr1 & same_addr);
      pf_vld1 <= miss1;
      pf_idx0 <= idx0;
      pf_idx1 <= idx1;
      pf_tag0 <= tag0;
      pf_tag1 <= tag1;
    end
  end

  // Later assignments win: port1 write > port0 write > port1 fill > port0 fill
  always_ff @(posedge mod_clk) begin
    if (pf_vld0) begin
      data_mem[pf_idx0] <= m_q0;
      tag_mem[pf_idx0]  <= pf_tag0;
    end
    if (pf_vld1) begin
      data_mem[pf_idx1] <= m_q1;
      tag_mem[pf_idx1]  <= pf_tag1;
    end
    if (wr0) begin
      data_mem[idx0] <= k_d0;
      tag_mem[idx0]  <= tag0;
    end
    if (wr1) begin
      data_mem[idx1] <= k_d1;
      tag_mem[idx1]  <= tag1;
    end
  end

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (pf_vld0) valid[pf_idx0] <= 1'b1;
      if (pf_vld1) valid[pf_idx1] <= 1'b1;
      if (wr0)     valid[idx0]    <= 1'b1;
      if (wr1)     valid[idx1]    <= 1'b1;
    end
  end

`ifdef SP_STATS_EN
  logic [1:0]  hit_inc, miss_inc;
  logic [32:0] hit_sum, miss_sum;

  // A coalesced port1 read is served without its own bridge access, so it counts as a hit
  assign hit_inc  = 2'(hit0) + 2'(hit1) + 2'(dedup);
  assign miss_inc = 2'(miss0) + 2'(miss1);
  assign hit_sum  = {1'b0, hit_cnt} + 33'(hit_inc);
  assign miss_sum = {1'b0, miss_cnt} + 33'(miss_inc);

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt  <= hit_sum[32]  ? '1 : hit_sum[31:0];
      miss_cnt <= miss_sum[32] ? '1 : miss_sum[31:0];
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_sp_hit_filter.sv
// tb/tb_sp_hit_filter.sv - scoreboard bench for sp_hit_filter
// Counter expectations follow SP_STATS_EN: model counts when defined, 0 otherwise.
module tb_sp_hit_filter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic          mod_clk = 1'b0;
  logic          reset, flush;
  logic [AW-1:0] k_addr0, k_addr1, m_addr0, m_addr1;
  logic          k_ce0, k_ce1, k_we0, k_we1;
  logic [DW-1:0] k_d0, k_d1, k_q0, k_q1, m_d0, m_d1, m_q0, m_q1;
  logic          m_ce0, m_ce1, m_we0, m_we1;
  logic [31:0]   hit_cnt, miss_cnt;

  sp_hit_filter dut (
    .mod_clk(mod_clk), .reset(reset), .flush(flush),
    .k_addr0(k_addr0), .k_addr1(k_addr1), .k_ce0(k_ce0), .k_ce1(k_ce1),
    .k_we0(k_we0), .k_we1(k_we1), .k_d0(k_d0), .k_d1(k_d1),
    .k_q0(k_q0), .k_q1(k_q1), .m_addr0(m_addr0), .m_addr1(m_addr1),
    .m_ce0(m_ce0), .m_ce1(m_ce1), .m_we0(m_we0), .m_we1(m_we1),
    .m_d0(m_d0), .m_d1(m_d1), .m_q0(m_q0), .m_q1(m_q1),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 mod_clk = ~mod_clk;

  typedef struct {
    int            port;
    logic [DW-1:0] exp;
    int            id;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  exp_hit = 0;
  int  exp_miss = 0;

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef SP_STATS_EN
    return 32'(v);
`else
    return (v < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  task automatic set_ports(input logic [AW-1:0] a0, input logic ce0, input logic we0, input logic [DW-1:0] d0,
                           input logic [AW-1:0] a1, input logic ce1, input logic we1, input logic [DW-1:0] d1);
    k_addr0 = a0; k_ce0 = ce0; k_we0 = we0; k_d0 = d0;
    k_addr1 = a1; k_ce1 = ce1; k_we1 = we1; k_d1 = d1;
  endtask

  task automatic expect_q(input int port, input logic [DW-1:0] exp, input int id);
    sb_t e;
    e.port = port; e.exp = exp; e.id = id;
    sb.push_back(e);
  endtask

  // Clock edge, then the bridge presents q0/q1 and queued read results are retired
  task automatic step(input logic [DW-1:0] q0, input logic [DW-1:0] q1);
    @(posedge mod_clk);
    #1;
    k_ce0 = 1'b0; k_ce1 = 1'b0; k_we0 = 1'b0; k_we1 = 1'b0;
    m_q0 = q0; m_q1 = q1;
    #1;
    while (sb.size() > 0) begin
      sb_t e;
      logic [DW-1:0] act;
      e = sb.pop_front();
      act = (e.port == 1) ? k_q1 : k_q0;
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL kq%0d_read%0d: got %h expected %h", e.port, e.id, act, e.exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; m_q0 = '0; m_q1 = '0;
    set_ports(14'h0, 0, 0, 0, 14'h0, 0, 0, 0);
    #2;
    tests++; if (k_q0 !== 32'd0) begin fails++; $display("FAIL rst_kq0: got %h expected 0", k_q0); end
    tests++; if (k_q1 !== 32'd0) begin fails++; $display("FAIL rst_kq1: got %h expected 0", k_q1); end
    tests++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      fails++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
    end
    tests++; if (m_ce0 !== 1'b0) begin fails++; $display("FAIL rst_mce0_idle: got %b expected 0", m_ce0); end
    set_ports(14'h0, 0, 0, 0, 14'h0003, 1, 0, 0);
    #1;
    tests++; if (m_ce1 !== 1'b1) begin fails++; $display("FAIL rst_mce1_follow: got %b expected 1", m_ce1); end
    set_ports(14'h0, 0, 0, 0, 14'h0, 0, 0, 0);
    @(posedge mod_clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic test_read_hit();
    set_ports(14'h0105, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1) begin fails++; $display("FAIL hit_first_mce0: got %b expected 1", m_ce0); end
    expect_q(0, 32'hDEADBEEF, 1); exp_miss++;
    step(32'hDEADBEEF, 32'h0);
    step(32'h0, 32'h0);
    set_ports(14'h0105, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b0) begin fails++; $display("FAIL hit_second_mce0: got %b expected 0", m_ce0); end
    expect_q(0, 32'hDEADBEEF, 2); exp_hit++;
    step(32'h5555AAAA, 32'h0);
    tests++; if (hit_cnt !== cnt_exp(exp_hit) || miss_cnt !== cnt_exp(exp_miss)) begin
      fails++; $display("FAIL hit_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, cnt_exp(exp_hit), cnt_exp(exp_miss));
    end
  endtask

  task automatic test_write_through();
    set_ports(14'h0005, 1, 1, 32'd7, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1 || m_we0 !== 1'b1 || m_d0 !== 32'd7 || m_addr0 !== 14'h0005) begin
      fails++; $display("FAIL wr_forward: got ce%b we%b d%h a%h expected ce1 we1 d7 a0005", m_ce0, m_we0, m_d0, m_addr0);
    end
    step(32'h0, 32'h0);
    set_ports(14'h0005, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b0) begin fails++; $display("FAIL wr_read_mce0: got %b expected 0", m_ce0); end
    expect_q(0, 32'd7, 3); exp_hit++;
    step(32'h11111111, 32'h0);
  endtask

  task automatic test_dedup();
    set_ports(14'h2000, 1, 0, 0, 14'h2000, 1, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1 || m_ce1 !== 1'b0) begin
      fails++; $display("FAIL dedup_mce: got %b%b expected 10", m_ce0, m_ce1);
    end
    expect_q(0, 32'hCAFEF00D, 4); expect_q(1, 32'hCAFEF00D, 5);
    exp_miss++; exp_hit++;
    step(32'hCAFEF00D, 32'h00000BAD);
    step(32'h0, 32'h0);
    set_ports(14'h0, 0, 0, 0, 14'h2000, 1, 0, 0);
    #1;
    tests++; if (m_ce1 !== 1'b0) begin fails++; $display("FAIL dedup_fill_mce1: got %b expected 0", m_ce1); end
    expect_q(1, 32'hCAFEF00D, 6); exp_hit++;
    step(32'h0, 32'h12345678);
    tests++; if (hit_cnt !== cnt_exp(exp_hit) || miss_cnt !== cnt_exp(exp_miss)) begin
      fails++; $display("FAIL dedup_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, cnt_exp(exp_hit), cnt_exp(exp_miss));
    end
  endtask

  task automatic test_alias();
    set_ports(14'h0010, 1, 0, 0, 14'h0, 0, 0, 0);
    expect_q(0, 32'hA0A0A0A0, 7); exp_miss++;
    step(32'hA0A0A0A0, 32'h0);
    step(32'h0, 32'h0);
    set_ports(14'h0110, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1) begin fails++; $display("FAIL alias_miss_mce0: got %b expected 1", m_ce0); end
    expect_q(0, 32'hB1B1B1B1, 8); exp_miss++;
    step(32'hB1B1B1B1, 32'h0);
    step(32'h0, 32'h0);
    set_ports(14'h0110, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b0) begin fails++; $display("FAIL alias_refill_hit: got %b expected 0", m_ce0); end
    expect_q(0, 32'hB1B1B1B1, 9); exp_hit++;
    step(32'h0, 32'h0);
    set_ports(14'h0010, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1) begin fails++; $display("FAIL alias_old_tag_miss: got %b expected 1", m_ce0); end
    expect_q(0, 32'hA0A0A0A0, 10); exp_miss++;
    step(32'hA0A0A0A0, 32'h0);
    step(32'h0, 32'h0);
  endtask

  task automatic test_flush();
    set_ports(14'h0020, 1, 0, 0, 14'h0031, 1, 0, 0);
    expect_q(0, 32'h20202020, 11); expect_q(1, 32'h31313131, 12); exp_miss += 2;
    step(32'h20202020, 32'h31313131);
    step(32'h0, 32'h0);
    flush = 1'b1;
    step(32'h0, 32'h0);
    flush = 1'b0;
    set_ports(14'h0020, 1, 0, 0, 14'h0031, 1, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1 || m_ce1 !== 1'b1) begin
      fails++; $display("FAIL flush_miss: got %b%b expected 11", m_ce0, m_ce1);
    end
    expect_q(0, 32'h02020202, 13); expect_q(1, 32'h13131313, 14); exp_miss += 2;
    step(32'h02020202, 32'h13131313);
    step(32'h0, 32'h0);
    set_ports(14'h0040, 1, 0, 0, 14'h0, 0, 0, 0);
    expect_q(0, 32'h40404040, 15); exp_miss++;
    step(32'h40404040, 32'h0);
    flush = 1'b1;
    step(32'h0, 32'h0);
    flush = 1'b0;
    set_ports(14'h0040, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1) begin fails++; $display("FAIL flush_fill_dropped: got %b expected 1", m_ce0); end
    expect_q(0, 32'h04040404, 16); exp_miss++;
    step(32'h04040404, 32'h0);
    step(32'h0, 32'h0);
    tests++; if (hit_cnt !== cnt_exp(exp_hit) || miss_cnt !== cnt_exp(exp_miss)) begin
      fails++; $display("FAIL flush_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, cnt_exp(exp_hit), cnt_exp(exp_miss));
    end
  endtask

  task automatic test_read_first();
    set_ports(14'h0060, 1, 0, 0, 14'h0, 0, 0, 0);
    expect_q(0, 32'h99, 17); exp_miss++;
    step(32'h99, 32'h0);
    step(32'h0, 32'h0);
    set_ports(14'h0060, 1, 1, 32'd5, 14'h0060, 1, 0, 0);
    #1;
    tests++; if (m_ce1 !== 1'b1 || m_ce0 !== 1'b1) begin
      fails++; $display("FAIL rf_forced_miss: got %b%b expected 11", m_ce0, m_ce1);
    end
    expect_q(1, 32'd5, 18); exp_miss++;
    step(32'h0, 32'd5);
    step(32'h0, 32'h0);
    set_ports(14'h0060, 1, 0, 0, 14'h0060, 1, 1, 32'd6);
    #1;
    tests++; if (m_ce0 !== 1'b0) begin fails++; $display("FAIL rf_port0_hit: got %b expected 0", m_ce0); end
    expect_q(0, 32'd5, 19); exp_hit++;
    step(32'h0, 32'h0);
    set_ports(14'h0060, 1, 0, 0, 14'h0, 0, 0, 0);
    expect_q(0, 32'd6, 20); exp_hit++;
    step(32'h0, 32'h0);
    tests++; if (hit_cnt !== cnt_exp(exp_hit) || miss_cnt !== cnt_exp(exp_miss)) begin
      fails++; $display("FAIL rf_cnt: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, cnt_exp(exp_hit), cnt_exp(exp_miss));
    end
  endtask

  task automatic test_reset_mid();
    set_ports(14'h0050, 1, 0, 0, 14'h0, 0, 0, 0);
    expect_q(0, 32'h50505050, 21);
    step(32'h50505050, 32'h0);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    exp_hit = 0; exp_miss = 0;
    tests++; if (k_q0 !== 32'd0) begin fails++; $display("FAIL midrst_kq0: got %h expected 0", k_q0); end
    tests++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      fails++; $display("FAIL midrst_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt);
    end
    step(32'h50505050, 32'h0);
    set_ports(14'h0050, 1, 0, 0, 14'h0, 0, 0, 0);
    #1;
    tests++; if (m_ce0 !== 1'b1) begin fails++; $display("FAIL midrst_no_fill: got %b expected 1", m_ce0); end
    expect_q(0, 32'h05050505, 22); exp_miss++;
    step(32'h05050505, 32'h0);
    tests++; if (hit_cnt !== cnt_exp(exp_hit) || miss_cnt !== cnt_exp(exp_miss)) begin
      fails++; $display("FAIL midrst_cnt_after: got %0d/%0d expected %0d/%0d", hit_cnt, miss_cnt, cnt_exp(exp_hit), cnt_exp(exp_miss));
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_through();
    test_dedup();
    test_alias();
    test_flush();
    test_read_first();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
